fp_div_norm_round: RTL and testbench

- Parametrised, pipelined back end for the FP divider. Takes the raw quotient, its signed biased exponent and sticky bit; produces an IEEE-754 result and exception flags.
- Adds the following over the current combinational FP32 normaliser:
  - configurable exponent and mantissa widths;
  - four rounding modes;
  - overflow, underflow and subnormal handling;
  - special-value passthrough;
  - valid/ready flow control.
- Sits between the divider iteration core and the FPU writeback.

---
 rtl/fp_pkg.sv | 15 +
 rtl/fp_lzc.sv | 18 +
 rtl/fp_div_norm_round.sv | 173 +++++++++++++++++
 tb/tb_fp_div_norm_round.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and flag indices for the FP divider back end
package fp_pkg;

    typedef enum logic [1:0] {
        RND_RNE = 2'd0,
        RND_RTZ = 2'd1,
        RND_RDN = 2'd2,
        RND_RUP = 2'd3
    } rnd_mode_e;

    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter; all-zero input yields W
module fp_lzc #(
    parameter int W = 26
) (
    input  logic [W-1:0]             a_i,
    output logic [$clog2(W+1)-1:0]   cnt_o
);
    localparam int CW = $clog2(W + 1);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        cnt_o = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (a_i[i]) cnt_o = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_div_norm_round.sv
// rtl/fp_div_norm_round.sv - two-stage normalise/round back end for the FP divider
module fp_div_norm_round
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int FTZ   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic [EXP_W+1:0]         in_exp,
    input  logic [MAN_W+2:0]         in_quot,
    input  logic                     in_sticky,
    input  logic                     in_nan,
    input  logic                     in_inf,
    input  logic                     in_zero,
    input  logic [1:0]               rnd_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic [2:0]               out_flags
);
    localparam int QW = MAN_W + 3;
    localparam int CW = $clog2(QW + 1);
    // One bit wider than the port so in_exp - lz never wraps.
    localparam int SW = EXP_W + 3;
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic [EXP_W-1:0]     EXP_MAXF = EXP_ONES - 1'b1;
    localparam logic [MAN_W-1:0]     QNAN_MAN = {1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [SW-1:0] S_ZERO   = '0;
    localparam logic signed [SW-1:0] S_ONE    = SW'(1);
    localparam logic signed [SW-1:0] S_QW     = SW'(QW);
    localparam logic signed [SW-1:0] EXP_OVF  = SW'((1 << EXP_W) - 1);

    logic                 s1_valid_q, s1_sign_q, s1_sticky_q, s1_nan_q, s1_inf_q;
    logic                 s1_zero_q, s1_tiny_q, s1_flush_q;
    rnd_mode_e            s1_rnd_q;
    logic signed [SW-1:0] s1_exp_q;
    logic [QW-1:0]        s1_mant_q;
    logic                 out_valid_q;
    logic [EXP_W+MAN_W:0] out_result_q;
    logic [2:0]           out_flags_q;

    logic s2_load, s1_advance;
    assign s2_load    = !out_valid_q | out_ready;
    assign s1_advance = s1_valid_q & s2_load;
    assign in_ready   = !s1_valid_q | s1_advance;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

    logic [CW-1:0] lz;
    fp_lzc #(.W(QW)) u_lzc (.a_i(in_quot), .cnt_o(lz));

    logic [QW-1:0]        norm_mant, sub_mask, s1_mant_d;
    logic signed [SW-1:0] e1, one_minus;
    logic [SW-1:0]        sh;
    logic                 tiny_d, s1_sticky_d;

    always_comb begin
        norm_mant   = in_quot << lz;
        e1          = $signed({in_exp[EXP_W+1], in_exp}) - $signed({{(SW-CW){1'b0}}, lz});
        tiny_d      = (e1 <= S_ZERO);
        one_minus   = S_ONE - e1;
        sh          = (one_minus > S_QW) ? S_QW : one_minus;
        sub_mask    = ~({QW{1'b1}} << sh);
        s1_mant_d   = norm_mant;
        s1_sticky_d = in_sticky;
        if (tiny_d) begin
            s1_mant_d   = norm_mant >> sh;
            s1_sticky_d = in_sticky | (|(norm_mant & sub_mask));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_sticky_q <= 1'b0;
            s1_nan_q    <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_tiny_q   <= 1'b0;
            s1_flush_q  <= 1'b0;
            s1_rnd_q    <= RND_RNE;
            s1_exp_q    <= '0;
            s1_mant_q   <= '0;
        end else begin
            if (in_ready) s1_valid_q <= in_valid;
            if (in_valid && in_ready) begin
                s1_sign_q   <= in_sign;
                s1_sticky_q <= s1_sticky_d;
                s1_nan_q    <= in_nan;
                s1_inf_q    <= in_inf;
                s1_zero_q   <= in_zero | (in_quot == '0);
                s1_tiny_q   <= tiny_d;
                s1_flush_q  <= (FTZ != 0) && tiny_d;
                s1_rnd_q    <= rnd_mode_e'(rnd_mode);
                s1_exp_q    <= e1;
                s1_mant_q   <= s1_mant_d;
            end
        end
    end

    logic                 g, r, lsb, inc, nx, carry, to_inf;
    logic [MAN_W+1:0]     sum;
    logic signed [SW-1:0] exp_f;
    logic [MAN_W-1:0]     man_f;
    logic [EXP_W+MAN_W:0] res_d;
    logic [2:0]           flags_d;

    always_comb begin
        g   = s1_mant_q[1];
        r   = s1_mant_q[0] | s1_sticky_q;
        lsb = s1_mant_q[2];
        nx  = g | r;
        inc = 1'b0;
        case (s1_rnd_q)
            RND_RNE: inc = g & (r | lsb);
            RND_RTZ: inc = 1'b0;
            RND_RDN: inc = s1_sign_q & nx;
            default: inc = !s1_sign_q & nx;
        endcase
        to_inf = (s1_rnd_q == RND_RNE) || (s1_rnd_q == RND_RUP && !s1_sign_q)
              || (s1_rnd_q == RND_RDN && s1_sign_q);
        sum   = {1'b0, s1_mant_q[QW-1:2]} + {{(MAN_W+1){1'b0}}, inc};
        carry = sum[MAN_W+1];
        // A subnormal that rounds into the hidden bit lands on exponent 1.
        exp_f = (s1_tiny_q ? S_ZERO : s1_exp_q) + SW'(carry) + SW'(s1_tiny_q & sum[MAN_W]);
        man_f = carry ? '0 : sum[MAN_W-1:0];

        flags_d = '0;
        res_d   = {s1_sign_q, exp_f[EXP_W-1:0], man_f};
        if (s1_nan_q) begin
            res_d = {1'b0, EXP_ONES, QNAN_MAN};
        end else if (s1_inf_q) begin
            res_d = {s1_sign_q, EXP_ONES, {MAN_W{1'b0}}};
        end else if (s1_zero_q) begin
            res_d = {s1_sign_q, {(EXP_W+MAN_W){1'b0}}};
        end else if (s1_flush_q) begin
            res_d           = {s1_sign_q, {(EXP_W+MAN_W){1'b0}}};
            flags_d[FLG_UF] = 1'b1;
            flags_d[FLG_NX] = 1'b1;
        end else begin
            flags_d[FLG_NX] = nx;
            flags_d[FLG_UF] = s1_tiny_q & nx;
            if (!s1_tiny_q && exp_f >= EXP_OVF) begin
                flags_d[FLG_OF] = 1'b1;
                flags_d[FLG_NX] = 1'b1;
                res_d = to_inf ? {s1_sign_q, EXP_ONES, {MAN_W{1'b0}}}
                               : {s1_sign_q, EXP_MAXF, {MAN_W{1'b1}}};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_result_q <= res_d;
                out_flags_q  <= flags_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_div_norm_round.sv
// tb/tb_fp_div_norm_round.sv - randomized and directed bench with a value-level rounding model
module tb_fp_div_norm_round;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_sign = 1'b0, in_sticky = 1'b0;
    logic        in_nan = 1'b0, in_inf = 1'b0, in_zero = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [25:0] in_quot = '0;
    logic [1:0]  rnd_mode = '0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, in_ready_f, out_valid_f;
    logic [31:0] out_result, out_result_f;
    logic [2:0]  out_flags, out_flags_f;

    always #5 clk = ~clk;

    fp_div_norm_round #(.EXP_W(8), .MAN_W(23), .FTZ(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_quot(in_quot), .in_sticky(in_sticky),
        .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero), .rnd_mode(rnd_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags)
    );

    fp_div_norm_round #(.EXP_W(8), .MAN_W(23), .FTZ(1)) u_dut_ftz (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_f),
        .in_sign(in_sign), .in_exp(in_exp), .in_quot(in_quot), .in_sticky(in_sticky),
        .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero), .rnd_mode(rnd_mode),
        .out_valid(out_valid_f), .out_ready(out_ready), .out_result(out_result_f),
        .out_flags(out_flags_f)
    );

    typedef struct {
        bit          sign;
        int          exp;
        logic [25:0] quot;
        bit          sticky, nan, inf, zero;
        logic [1:0]  rnd;
    } beat_t;

    typedef struct {
        logic [31:0] r0;
        logic [2:0]  f0;
        logic [31:0] r1;
        logic [2:0]  f1;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Value-level reference: value = quot * 2^(exp-152); quantise to the ulp of the target binade.
    function automatic logic [34:0] model(input beat_t b, input bit ftz);
        int p, e, k, d;
        longint unsigned q, n, rem, half;
        bit tiny, nx, above, tie, inc, toinf;
        logic [31:0] res;
        logic [2:0]  fl;
        if (b.nan) return {3'b0, 32'h7FC00000};
        if (b.inf) return {3'b0, b.sign, 31'h7F800000};
        if (b.zero || b.quot == 0) return {3'b0, b.sign, 31'h0};
        q = longint'(b.quot);
        p = 0;
        for (int i = 0; i < 26; i++) if (q[i]) p = i;
        e    = b.exp - (25 - p);
        tiny = (e <= 0);
        if (tiny && ftz) return {3'b011, b.sign, 31'h0};
        k = b.exp - (tiny ? 1 : e) - 2;
        above = 0; tie = 0; rem = 0;
        if (k >= 0) begin
            n = q << k;
        end else begin
            d = -k;
            if (d > 40) d = 40;
            n     = q >> d;
            rem   = q & ((64'd1 << d) - 1);
            half  = 64'd1 << (d - 1);
            above = (rem > half) || (rem == half && b.sticky);
            tie   = (rem == half) && !b.sticky;
        end
        nx = (rem != 0) || b.sticky;
        case (b.rnd)
            2'd0:    inc = above || (tie && n[0]);
            2'd1:    inc = 0;
            2'd2:    inc = b.sign && nx;
            default: inc = !b.sign && nx;
        endcase
        n = n + longint'(inc);
        if (tiny) begin
            res = {b.sign, 7'b0, n[23], n[22:0]};
            fl  = {1'b0, nx, nx};
        end else begin
            if (n == (64'd1 << 24)) begin
                n = 64'd1 << 23;
                e++;
            end
            if (e >= 255) begin
                toinf = (b.rnd == 2'd0) || (b.rnd == 2'd3 && !b.sign) || (b.rnd == 2'd2 && b.sign);
                res   = toinf ? {b.sign, 31'h7F800000} : {b.sign, 31'h7F7FFFFF};
                fl    = 3'b101;
            end else begin
                res = {b.sign, e[7:0], n[22:0]};
                fl  = {2'b00, nx};
            end
        end
        return {fl, res};
    endfunction

    function automatic exp_t mk(input beat_t b);
        exp_t x;
        logic [34:0] m0, m1;
        m0 = model(b, 1'b0);
        m1 = model(b, 1'b1);
        x.r0 = m0[31:0]; x.f0 = m0[34:32];
        x.r1 = m1[31:0]; x.f1 = m1[34:32];
        return x;
    endfunction

    function automatic exp_t lit(input logic [31:0] r0, input logic [2:0] f0,
                                 input logic [31:0] r1, input logic [2:0] f1);
        exp_t x;
        x.r0 = r0; x.f0 = f0; x.r1 = r1; x.f1 = f1;
        return x;
    endfunction

    function automatic beat_t bt(input bit s, input int e, input logic [25:0] q,
                                 input bit st, input logic [1:0] rm);
        beat_t b;
        b.sign = s; b.exp = e; b.quot = q; b.sticky = st; b.rnd = rm;
        b.nan = 0; b.inf = 0; b.zero = 0;
        return b;
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        int    cat, shamt;
        logic [25:0] q;
        q     = 26'($urandom) | 26'h2000000;
        shamt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 26)) : int'($urandom_range(0, 3));
        cat   = int'($urandom_range(0, 9));
        b = bt(1'($urandom), 0, q >> shamt, 1'($urandom), 2'($urandom));
        if (cat < 6)       b.exp = int'($urandom_range(100, 160));
        else if (cat == 6) b.exp = int'($urandom_range(245, 300));
        else if (cat == 7) b.exp = int'($urandom_range(0, 35)) - 30;
        else if (cat == 8) b.exp = int'($urandom_range(0, 40)) - 60;
        else               b.exp = int'($urandom_range(0, 8)) - 2;
        b.nan  = ($urandom_range(0, 19) == 0);
        b.inf  = ($urandom_range(0, 19) == 0);
        b.zero = ($urandom_range(0, 19) == 0);
        return b;
    endfunction

    task automatic step(input bit v, input bit rdy, input beat_t b, input exp_t e, output bit acc);
        exp_t x;
        in_valid  = v;
        in_sign   = b.sign;
        in_exp    = b.exp[9:0];
        in_quot   = b.quot;
        in_sticky = b.sticky;
        in_nan    = b.nan;
        in_inf    = b.inf;
        in_zero   = b.zero;
        rnd_mode  = b.rnd;
        out_ready = rdy;
        #1;
        acc = v && in_ready && in_ready_f;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                x = sb.pop_front();
                chk("result", out_result, x.r0);
                chk("flags", out_flags, x.f0);
                chk("valid_ftz", out_valid_f, 1);
                chk("result_ftz", out_result_f, x.r1);
                chk("flags_ftz", out_flags_f, x.f1);
            end
        end
        if (acc) sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic send(input beat_t b, input exp_t e);
        bit acc;
        acc = 0;
        for (int i = 0; i < 20 && !acc; i++) step(1, 1, b, e, acc);
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        bit acc;
        beat_t idle;
        idle = bt(0, 127, 26'h2000000, 0, 2'd0);
        for (int i = 0; i < 60 && sb.size() > 0; i++) step(0, 1, idle, mk(idle), acc);
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        bit          acc;
        beat_t       idle, b, fb[4];
        int          idx;
        logic [31:0] hold_res;
        logic [2:0]  hold_flags;

        idle = bt(0, 127, 26'h2000000, 0, 2'd0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: accept edge, then result visible after the following edge.
        step(1, 1, idle, lit(32'h3F800000, 3'b000, 32'h3F800000, 3'b000), acc);
        chk("lat_accept", acc, 1);
        chk("lat_edge1_valid", out_valid, 0);
        step(0, 1, idle, mk(idle), acc);
        chk("lat_edge2_valid", out_valid, 1);
        drain();

        send(bt(0, 127, 26'h1000000, 0, 2'd0), lit(32'h3F000000, 3'b000, 32'h3F000000, 3'b000));
        send(bt(0, 127, 26'h0000000, 0, 2'd0), lit(32'h00000000, 3'b000, 32'h00000000, 3'b000));
        send(bt(0, 127, 26'h2000002, 0, 2'd0), lit(32'h3F800000, 3'b001, 32'h3F800000, 3'b001));
        send(bt(0, 127, 26'h2000002, 0, 2'd3), lit(32'h3F800001, 3'b001, 32'h3F800001, 3'b001));
        send(bt(1, 127, 26'h2000002, 0, 2'd2), lit(32'hBF800001, 3'b001, 32'hBF800001, 3'b001));
        send(bt(0, 127, 26'h3FFFFFE, 0, 2'd0), lit(32'h40000000, 3'b001, 32'h40000000, 3'b001));
        send(bt(0, 300, 26'h2000000, 0, 2'd0), lit(32'h7F800000, 3'b101, 32'h7F800000, 3'b101));
        send(bt(0, 300, 26'h2000000, 0, 2'd1), lit(32'h7F7FFFFF, 3'b101, 32'h7F7FFFFF, 3'b101));
        send(bt(0, -2,  26'h2000000, 0, 2'd0), lit(32'h00100000, 3'b000, 32'h00000000, 3'b011));
        send(bt(0, -30, 26'h2000000, 0, 2'd0), lit(32'h00000000, 3'b011, 32'h00000000, 3'b011));
        drain();

        // Stall: two beats fill both stages, then the input side must back off.
        for (int i = 0; i < 4; i++) fb[i] = bt(1'($urandom), int'($urandom_range(100, 150)),
                                              26'($urandom) | 26'h2000000, 1'($urandom), 2'($urandom));
        idx = 0;
        hold_res = '0;
        hold_flags = '0;
        for (int c = 0; c < 5; c++) begin
            step(1, 0, fb[idx], mk(fb[idx]), acc);
            if (acc) idx++;
            if (c == 2) begin
                hold_res   = out_result;
                hold_flags = out_flags;
            end
        end
        chk("stall_accepts", idx, 2);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_valid", out_valid, 1);
        chk("stall_hold_result", out_result, hold_res);
        chk("stall_hold_flags", out_flags, hold_flags);
        for (int c = 0; c < 30 && idx < 4; c++) begin
            step(1, 1, fb[idx], mk(fb[idx]), acc);
            if (acc) idx++;
        end
        chk("stream_all_accepted", idx, 4);
        drain();

        // Asynchronous reset with beats in flight.
        for (int c = 0; c < 3; c++) step(1, 0, fb[c], mk(fb[c]), acc);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(0, 1, idle, mk(idle), acc);
            chk("post_rst_idle", out_valid, 0);
        end

        b = bt(0, 127, 26'h2000000, 0, 2'd0);
        b.nan = 1;
        send(b, lit(32'h7FC00000, 3'b000, 32'h7FC00000, 3'b000));
        drain();

        for (int c = 0; c < 500; c++) begin
            b = rnd_beat();
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, b, mk(b), acc);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
